// File: rtl/spi_slave_bus_arbiter.sv
// Round-robin arbiter between an SPI-slave burst requester (rq0) and a local requester (rq1)
// onto one shared memory port. Optional bus watchdog: define SPI_SLAVE_ARB_TIMEOUT_EN.
module spi_slave_bus_arbiter #(
  parameter int unsigned ADDR_STEP      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        axi_aclk,
  input  logic        axi_aresetn,
  input  logic [31:0] rq0_addr,
  input  logic        rq0_addr_valid,
  input  logic        rq0_rd_wr,
  input  logic        rq0_burst_end,
  input  logic [31:0] rq0_wdata,
  input  logic        rq0_wdata_valid,
  output logic        rq0_wdata_ready,
  output logic [31:0] rq0_rdata,
  output logic        rq0_rdata_valid,
  input  logic        rq0_rdata_ready,
  input  logic        rq1_req,
  output logic        rq1_gnt,
  input  logic        rq1_we,
  input  logic [31:0] rq1_addr,
  input  logic [31:0] rq1_wdata,
  output logic        rq1_rvalid,
  output logic [31:0] rq1_rdata,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        err_timeout
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q, state_d;
  logic        burst_active_q, burst_active_d;
  logic        burst_rd_q, burst_rd_d;
  logic [31:0] burst_addr_q, burst_addr_d;
  logic        last_rq1_q, last_rq1_d;
  logic        owner_rq1_q, owner_rq1_d;
  logic        owner_rd_q, owner_rd_d;
  logic        discard_q, discard_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rq0_rdata_q, rq0_rdata_d;
  logic        rq0_rdata_valid_q, rq0_rdata_valid_d;
  logic        rq0_wdata_ready_q, rq0_wdata_ready_d;
  logic        rq1_gnt_q, rq1_gnt_d;
  logic        rq1_rvalid_q, rq1_rvalid_d;
  logic [31:0] rq1_rdata_q, rq1_rdata_d;

  logic        rq0_elig, rq1_elig, pick_rq1;
  logic        tmo_fire, mem_done, resp_fire;
  logic [31:0] resp_data;

`ifdef SPI_SLAVE_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        err_q;

  assign tmo_fire    = (state_q != StIdle) && (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign err_timeout = err_q;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= (state_q == StIdle) ? '0 : tmo_cnt_q + 16'd1;
      if (tmo_fire) err_q <= 1'b1;
    end
  end
`else
  assign tmo_fire    = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Only evaluated in IDLE, where no rq0 beat can be in flight.
  assign rq0_elig  = burst_active_q && (burst_rd_q ? !rq0_rdata_valid_q : rq0_wdata_valid);
  assign rq1_elig  = rq1_req;
  assign pick_rq1  = rq1_elig && (!rq0_elig || !last_rq1_q);
  assign mem_done  = (state_q == StWait) && mem_rvalid;
  assign resp_fire = mem_done || tmo_fire;
  assign resp_data = mem_done ? mem_rdata : 32'hDEADBEEF;

  always_comb begin
    state_d           = state_q;
    burst_active_d    = burst_active_q;
    burst_rd_d        = burst_rd_q;
    burst_addr_d      = burst_addr_q;
    last_rq1_d        = last_rq1_q;
    owner_rq1_d       = owner_rq1_q;
    owner_rd_d        = owner_rd_q;
    discard_d         = discard_q;
    mem_req_d         = mem_req_q;
    mem_we_d          = mem_we_q;
    mem_addr_d        = mem_addr_q;
    mem_wdata_d       = mem_wdata_q;
    rq0_rdata_d       = rq0_rdata_q;
    rq0_rdata_valid_d = rq0_rdata_valid_q;
    rq0_wdata_ready_d = 1'b0;
    rq1_gnt_d         = 1'b0;
    rq1_rvalid_d      = 1'b0;
    rq1_rdata_d       = rq1_rdata_q;

    if (rq0_addr_valid) begin
      burst_active_d = 1'b1;
      burst_addr_d   = rq0_addr;
      burst_rd_d     = rq0_rd_wr;
    end else if (rq0_burst_end) begin
      burst_active_d = 1'b0;
    end

    if (rq0_burst_end || rq0_rdata_ready) rq0_rdata_valid_d = 1'b0;
    if ((state_q != StIdle) && !owner_rq1_q && rq0_burst_end) discard_d = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (rq0_elig || rq1_elig) begin
          state_d     = StReq;
          mem_req_d   = 1'b1;
          owner_rq1_d = pick_rq1;
          last_rq1_d  = pick_rq1;
          if (pick_rq1) begin
            mem_we_d    = rq1_we;
            mem_addr_d  = rq1_addr;
            mem_wdata_d = rq1_wdata;
            owner_rd_d  = !rq1_we;
            discard_d   = 1'b0;
            rq1_gnt_d   = 1'b1;
          end else begin
            mem_we_d          = !burst_rd_q;
            mem_addr_d        = burst_addr_q;
            mem_wdata_d       = burst_rd_q ? '0 : rq0_wdata;
            owner_rd_d        = burst_rd_q;
            discard_d         = rq0_burst_end;
            rq0_wdata_ready_d = !burst_rd_q;
            // A fresh burst start in the same cycle keeps its own base address.
            if (!rq0_addr_valid) burst_addr_d = burst_addr_q + 32'(ADDR_STEP);
          end
        end
      end
      StReq: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = StWait;
        end
      end
      StWait: ;
      default: state_d = StIdle;
    endcase

    if (resp_fire) begin
      state_d   = StIdle;
      mem_req_d = 1'b0;
      if (owner_rq1_q) begin
        rq1_rvalid_d = 1'b1;
        rq1_rdata_d  = resp_data;
      end else if (owner_rd_q && !discard_q && !rq0_burst_end) begin
        rq0_rdata_d       = resp_data;
        rq0_rdata_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q           <= StIdle;
      burst_active_q    <= 1'b0;
      burst_rd_q        <= 1'b0;
      burst_addr_q      <= '0;
      last_rq1_q        <= 1'b1;
      owner_rq1_q       <= 1'b0;
      owner_rd_q        <= 1'b0;
      discard_q         <= 1'b0;
      mem_req_q         <= 1'b0;
      mem_we_q          <= 1'b0;
      mem_addr_q        <= '0;
      mem_wdata_q       <= '0;
      rq0_rdata_q       <= '0;
      rq0_rdata_valid_q <= 1'b0;
      rq0_wdata_ready_q <= 1'b0;
      rq1_gnt_q         <= 1'b0;
      rq1_rvalid_q      <= 1'b0;
      rq1_rdata_q       <= '0;
    end else begin
      state_q           <= state_d;
      burst_active_q    <= burst_active_d;
      burst_rd_q        <= burst_rd_d;
      burst_addr_q      <= burst_addr_d;
      last_rq1_q        <= last_rq1_d;
      owner_rq1_q       <= owner_rq1_d;
      owner_rd_q        <= owner_rd_d;
      discard_q         <= discard_d;
      mem_req_q         <= mem_req_d;
      mem_we_q          <= mem_we_d;
      mem_addr_q        <= mem_addr_d;
      mem_wdata_q       <= mem_wdata_d;
      rq0_rdata_q       <= rq0_rdata_d;
      rq0_rdata_valid_q <= rq0_rdata_valid_d;
      rq0_wdata_ready_q <= rq0_wdata_ready_d;
      rq1_gnt_q         <= rq1_gnt_d;
      rq1_rvalid_q      <= rq1_rvalid_d;
      rq1_rdata_q       <= rq1_rdata_d;
    end
  end

  assign mem_req         = mem_req_q;
  assign mem_we          = mem_we_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign rq0_rdata       = rq0_rdata_q;
  assign rq0_rdata_valid = rq0_rdata_valid_q;
  assign rq0_wdata_ready = rq0_wdata_ready_q;
  assign rq1_gnt         = rq1_gnt_q;
  assign rq1_rvalid      = rq1_rvalid_q;
  assign rq1_rdata       = rq1_rdata_q;

endmodule
